alu_share_arbiter: RTL and testbench

Shares one combinational integer ALU between two requesters, e.g. the main execute pipe (requester 0) and the branch/address unit (requester 1). Each requester has a valid/ready request channel and a valid/ready response channel. The block arbitrates between them, drives the ALU ports, and captures the result into a one-entry response register for each requester. It sits between the issue logic and the ALU instance and keeps a running count of completed operations.

---
 rtl/alu_share_arbiter.sv | 153 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Arbitrates two requesters onto one combinational ALU and registers each result in a per-requester response slot.
// The response is valid one cycle after the request handshake. A full slot that is not being drained blocks only its own requester.
module alu_share_arbiter #(
  parameter int TAG_W      = 4,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req0_valid,
  output logic             io_req0_ready,
  input  logic [3:0]       io_req0_fn,
  input  logic [31:0]      io_req0_in1,
  input  logic [31:0]      io_req0_in2,
  input  logic [TAG_W-1:0] io_req0_tag,
  input  logic             io_req1_valid,
  output logic             io_req1_ready,
  input  logic [3:0]       io_req1_fn,
  input  logic [31:0]      io_req1_in1,
  input  logic [31:0]      io_req1_in2,
  input  logic [TAG_W-1:0] io_req1_tag,
  output logic             io_resp0_valid,
  input  logic             io_resp0_ready,
  output logic [31:0]      io_resp0_out,
  output logic [31:0]      io_resp0_adder_out,
  output logic             io_resp0_cmp_out,
  output logic [TAG_W-1:0] io_resp0_tag,
  output logic             io_resp1_valid,
  input  logic             io_resp1_ready,
  output logic [31:0]      io_resp1_out,
  output logic [31:0]      io_resp1_adder_out,
  output logic             io_resp1_cmp_out,
  output logic [TAG_W-1:0] io_resp1_tag,
  output logic [3:0]       io_alu_fn,
  output logic [31:0]      io_alu_in1,
  output logic [31:0]      io_alu_in2,
  input  logic [31:0]      io_alu_out,
  input  logic [31:0]      io_alu_adder_out,
  input  logic             io_alu_cmp_out,
  output logic [1:0]       io_grant,
  output logic [31:0]      io_ops_done
);

  logic [1:0]       req_valid;
  logic [1:0]       resp_ready;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [TAG_W-1:0] req_tag [2];

  logic             last_grant_q, last_grant_d;
  logic [31:0]      ops_done_q, ops_done_d;
  logic [1:0]       resp_valid_q, resp_valid_d;
  logic [1:0]       resp_cmp_q, resp_cmp_d;
  logic [31:0]      resp_out_q [2];
  logic [31:0]      resp_out_d [2];
  logic [31:0]      resp_adder_q [2];
  logic [31:0]      resp_adder_d [2];
  logic [TAG_W-1:0] resp_tag_q [2];
  logic [TAG_W-1:0] resp_tag_d [2];

  assign req_valid  = {io_req1_valid, io_req0_valid};
  assign resp_ready = {io_resp1_ready, io_resp0_ready};
  assign req_tag[0] = io_req0_tag;
  assign req_tag[1] = io_req1_tag;

  // A slot being drained this cycle can accept a new result on the same edge.
  assign elig = req_valid & (~resp_valid_q | resp_ready);

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      case (elig)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (PRIO_FIXED || last_grant_q) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Idle cycles present a static ADD of zeros so the ALU inputs do not toggle.
  always_comb begin
    io_alu_fn  = 4'd0;
    io_alu_in1 = 32'd0;
    io_alu_in2 = 32'd0;
    if (grant[0]) begin
      io_alu_fn  = io_req0_fn;
      io_alu_in1 = io_req0_in1;
      io_alu_in2 = io_req0_in2;
    end else if (grant[1]) begin
      io_alu_fn  = io_req1_fn;
      io_alu_in1 = io_req1_in1;
      io_alu_in2 = io_req1_in2;
    end
  end

  always_comb begin
    last_grant_d = (grant != 2'b00) ? grant[1] : last_grant_q;
    ops_done_d   = ops_done_q + {31'd0, |grant};
    resp_valid_d = resp_valid_q;
    resp_cmp_d   = resp_cmp_q;
    resp_out_d   = resp_out_q;
    resp_adder_d = resp_adder_q;
    resp_tag_d   = resp_tag_q;
    for (int n = 0; n < 2; n++) begin
      if (grant[n]) begin
        resp_valid_d[n] = 1'b1;
        resp_out_d[n]   = io_alu_out;
        resp_adder_d[n] = io_alu_adder_out;
        resp_cmp_d[n]   = io_alu_cmp_out;
        resp_tag_d[n]   = req_tag[n];
      end else if (resp_valid_q[n] && resp_ready[n]) begin
        resp_valid_d[n] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      ops_done_q   <= 32'd0;
      resp_valid_q <= 2'b00;
      resp_cmp_q   <= 2'b00;
      resp_out_q   <= '{default: '0};
      resp_adder_q <= '{default: '0};
      resp_tag_q   <= '{default: '0};
    end else begin
      last_grant_q <= last_grant_d;
      ops_done_q   <= ops_done_d;
      resp_valid_q <= resp_valid_d;
      resp_cmp_q   <= resp_cmp_d;
      resp_out_q   <= resp_out_d;
      resp_adder_q <= resp_adder_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

  assign io_grant      = grant;
  assign io_req0_ready = grant[0];
  assign io_req1_ready = grant[1];
  assign io_ops_done   = ops_done_q;

  assign io_resp0_valid     = resp_valid_q[0];
  assign io_resp0_out       = resp_out_q[0];
  assign io_resp0_adder_out = resp_adder_q[0];
  assign io_resp0_cmp_out   = resp_cmp_q[0];
  assign io_resp0_tag       = resp_tag_q[0];
  assign io_resp1_valid     = resp_valid_q[1];
  assign io_resp1_out       = resp_out_q[1];
  assign io_resp1_adder_out = resp_adder_q[1];
  assign io_resp1_cmp_out   = resp_cmp_q[1];
  assign io_resp1_tag       = resp_tag_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a round-robin instance and a fixed-priority instance share stimulus, each with its own ALU model.
module tb_alu_share_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_fn, req1_fn;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [3:0]  req0_tag, req1_tag;
  logic        resp0_ready, resp1_ready;

  logic        a_req0_ready, a_req1_ready, a_resp0_valid, a_resp1_valid;
  logic [31:0] a_resp0_out, a_resp0_adder, a_resp1_out, a_resp1_adder;
  logic        a_resp0_cmp, a_resp1_cmp;
  logic [3:0]  a_resp0_tag, a_resp1_tag;
  logic [3:0]  a_alu_fn;
  logic [31:0] a_alu_in1, a_alu_in2, a_alu_out, a_alu_adder;
  logic        a_alu_cmp;
  logic [1:0]  a_grant;
  logic [31:0] a_ops;

  logic        b_req0_ready, b_req1_ready, b_resp0_valid, b_resp1_valid;
  logic [31:0] b_resp0_out, b_resp0_adder, b_resp1_out, b_resp1_adder;
  logic        b_resp0_cmp, b_resp1_cmp;
  logic [3:0]  b_resp0_tag, b_resp1_tag;
  logic [3:0]  b_alu_fn;
  logic [31:0] b_alu_in1, b_alu_in2, b_alu_out, b_alu_adder;
  logic        b_alu_cmp;
  logic [1:0]  b_grant;
  logic [31:0] b_ops;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  // Returns {cmp, adder, out}; the adder subtracts for fn[3] set.
  function automatic logic [64:0] alu_model(input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] sum, res;
    logic        cmp;
    sum = fn[3] ? a - b : a + b;
    case (fn)
      4'd2:    cmp = (a == b);
      4'd3:    cmp = (a != b);
      4'd12:   cmp = ($signed(a) < $signed(b));
      4'd13:   cmp = !($signed(a) < $signed(b));
      4'd14:   cmp = (a < b);
      4'd15:   cmp = !(a < b);
      default: cmp = 1'b0;
    endcase
    case (fn)
      4'd0, 4'd10: res = sum;
      4'd1:        res = a << b[4:0];
      4'd4:        res = a ^ b;
      4'd5:        res = a >> b[4:0];
      4'd6:        res = a | b;
      4'd7:        res = a & b;
      4'd11:       res = $unsigned($signed(a) >>> b[4:0]);
      4'd2, 4'd3, 4'd12, 4'd13, 4'd14, 4'd15: res = {31'd0, cmp};
      default:     res = 32'd0;
    endcase
    return {cmp, sum, res};
  endfunction

  assign {a_alu_cmp, a_alu_adder, a_alu_out} = alu_model(a_alu_fn, a_alu_in1, a_alu_in2);
  assign {b_alu_cmp, b_alu_adder, b_alu_out} = alu_model(b_alu_fn, b_alu_in1, b_alu_in2);

  alu_share_arbiter #(.TAG_W(4), .PRIO_FIXED(1'b0)) dut_rr (
    .clock(clock), .reset(reset),
    .io_req0_valid(req0_valid), .io_req0_ready(a_req0_ready), .io_req0_fn(req0_fn),
    .io_req0_in1(req0_in1), .io_req0_in2(req0_in2), .io_req0_tag(req0_tag),
    .io_req1_valid(req1_valid), .io_req1_ready(a_req1_ready), .io_req1_fn(req1_fn),
    .io_req1_in1(req1_in1), .io_req1_in2(req1_in2), .io_req1_tag(req1_tag),
    .io_resp0_valid(a_resp0_valid), .io_resp0_ready(resp0_ready), .io_resp0_out(a_resp0_out),
    .io_resp0_adder_out(a_resp0_adder), .io_resp0_cmp_out(a_resp0_cmp), .io_resp0_tag(a_resp0_tag),
    .io_resp1_valid(a_resp1_valid), .io_resp1_ready(resp1_ready), .io_resp1_out(a_resp1_out),
    .io_resp1_adder_out(a_resp1_adder), .io_resp1_cmp_out(a_resp1_cmp), .io_resp1_tag(a_resp1_tag),
    .io_alu_fn(a_alu_fn), .io_alu_in1(a_alu_in1), .io_alu_in2(a_alu_in2),
    .io_alu_out(a_alu_out), .io_alu_adder_out(a_alu_adder), .io_alu_cmp_out(a_alu_cmp),
    .io_grant(a_grant), .io_ops_done(a_ops)
  );

  alu_share_arbiter #(.TAG_W(4), .PRIO_FIXED(1'b1)) dut_fixed (
    .clock(clock), .reset(reset),
    .io_req0_valid(req0_valid), .io_req0_ready(b_req0_ready), .io_req0_fn(req0_fn),
    .io_req0_in1(req0_in1), .io_req0_in2(req0_in2), .io_req0_tag(req0_tag),
    .io_req1_valid(req1_valid), .io_req1_ready(b_req1_ready), .io_req1_fn(req1_fn),
    .io_req1_in1(req1_in1), .io_req1_in2(req1_in2), .io_req1_tag(req1_tag),
    .io_resp0_valid(b_resp0_valid), .io_resp0_ready(resp0_ready), .io_resp0_out(b_resp0_out),
    .io_resp0_adder_out(b_resp0_adder), .io_resp0_cmp_out(b_resp0_cmp), .io_resp0_tag(b_resp0_tag),
    .io_resp1_valid(b_resp1_valid), .io_resp1_ready(resp1_ready), .io_resp1_out(b_resp1_out),
    .io_resp1_adder_out(b_resp1_adder), .io_resp1_cmp_out(b_resp1_cmp), .io_resp1_tag(b_resp1_tag),
    .io_alu_fn(b_alu_fn), .io_alu_in1(b_alu_in1), .io_alu_in2(b_alu_in2),
    .io_alu_out(b_alu_out), .io_alu_adder_out(b_alu_adder), .io_alu_cmp_out(b_alu_cmp),
    .io_grant(b_grant), .io_ops_done(b_ops)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_fn = 4'd0; req0_in1 = 32'd0; req0_in2 = 32'd0; req0_tag = 4'd0;
    req1_valid = 1'b0; req1_fn = 4'd0; req1_in1 = 32'd0; req1_in2 = 32'd0; req1_tag = 4'd0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;

    // Reset state; a pending request must not be granted while reset is high.
    #2;
    chk("rst_grant", a_grant, 2'b00);
    chk("rst_resp0_valid", a_resp0_valid, 1'b0);
    chk("rst_resp1_valid", a_resp1_valid, 1'b0);
    chk("rst_resp0_out", a_resp0_out, 32'd0);
    chk("rst_ops", a_ops, 32'd0);
    chk("rst_alu_fn", a_alu_fn, 4'd0);

    // ADD 5+3 on requester 0
    tick();
    reset = 1'b0;
    req0_fn = 4'd0; req0_in1 = 32'd5; req0_in2 = 32'd3; req0_tag = 4'd5;
    #1;
    chk("add_grant", a_grant, 2'b01);
    chk("add_ready0", a_req0_ready, 1'b1);
    chk("add_alu_in1", a_alu_in1, 32'd5);
    chk("add_alu_in2", a_alu_in2, 32'd3);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("add_resp_valid", a_resp0_valid, 1'b1);
    chk("add_resp_out", a_resp0_out, 32'd8);
    chk("add_resp_adder", a_resp0_adder, 32'd8);
    chk("add_resp_tag", a_resp0_tag, 4'd5);
    chk("idle_grant", a_grant, 2'b00);
    chk("idle_alu_in1", a_alu_in1, 32'd0);

    // SUB then SLT on requester 1, back to back
    req1_valid = 1'b1; req1_fn = 4'd10; req1_in1 = 32'd3; req1_in2 = 32'd5; req1_tag = 4'd3;
    #1;
    chk("sub_grant", a_grant, 2'b10);
    chk("sub_ready1", a_req1_ready, 1'b1);
    tick();
    req1_fn = 4'd12; req1_in1 = 32'hFFFF_FFFF; req1_in2 = 32'd1; req1_tag = 4'd7;
    #1;
    chk("sub_resp_out", a_resp1_out, 32'hFFFF_FFFE);
    chk("sub_resp_tag", a_resp1_tag, 4'd3);
    chk("slt_grant", a_grant, 2'b10);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("slt_resp_valid", a_resp1_valid, 1'b1);
    chk("slt_resp_out", a_resp1_out, 32'd1);
    chk("slt_resp_cmp", a_resp1_cmp, 1'b1);
    chk("slt_resp_tag", a_resp1_tag, 4'd7);
    chk("ops_after_three", a_ops, 32'd3);

    // Backpressure: fill resp0 and hold it while requester 1 streams
    resp0_ready = 1'b0;
    req0_valid = 1'b1; req0_fn = 4'd0; req0_in1 = 32'd10; req0_in2 = 32'd20; req0_tag = 4'd1;
    #1;
    chk("bp_fill_grant", a_grant, 2'b01);
    tick();
    req0_in1 = 32'd1; req0_in2 = 32'd1; req0_tag = 4'd2;
    req1_valid = 1'b1; req1_fn = 4'd0; req1_in2 = 32'd0;
    for (int k = 1; k <= 3; k++) begin
      req1_in1 = 32'd100 + k;
      req1_tag = k[3:0];
      #1;
      chk("bp_grant1", a_grant, 2'b10);
      chk("bp_ready0", a_req0_ready, 1'b0);
      chk("bp_resp0_out", a_resp0_out, 32'd30);
      chk("bp_resp0_tag", a_resp0_tag, 4'd1);
      tick();
    end
    resp0_ready = 1'b1;
    #1;
    chk("bp_release_grant", a_grant, 2'b01);
    chk("bp_resp1_out", a_resp1_out, 32'd103);
    chk("bp_resp1_tag", a_resp1_tag, 4'd3);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("bp_new_out", a_resp0_out, 32'd2);
    chk("bp_new_tag", a_resp0_tag, 4'd2);

    // Full throughput on requester 0: ADD i+1 every cycle
    for (int i = 0; i < 8; i++) begin
      req0_in1 = i;
      req0_in2 = 32'd1;
      req0_tag = i[3:0];
      #1;
      chk("tp_grant", a_grant, 2'b01);
      tick();
      chk("tp_valid", a_resp0_valid, 1'b1);
      chk("tp_out", a_resp0_out, i + 1);
    end

    // Asynchronous reset with resp0 full
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", a_resp0_valid, 1'b0);
    chk("mid_rst_ops", a_ops, 32'd0);
    chk("mid_rst_grant", a_grant, 2'b00);
    tick();
    tick();
    reset = 1'b0;

    // Contention from reset: round-robin alternates, fixed priority keeps requester 0
    req0_valid = 1'b1; req0_fn = 4'd0; req0_in1 = 32'd1; req0_in2 = 32'd2; req0_tag = 4'd1;
    req1_valid = 1'b1; req1_fn = 4'd0; req1_in1 = 32'd3; req1_in2 = 32'd4; req1_tag = 4'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_grant", a_grant, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("fixed_grant", b_grant, 2'b01);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("rr_ops", a_ops, 32'd4);
    chk("fixed_ops", b_ops, 32'd4);
    chk("rr_resp1_out", a_resp1_out, 32'd7);
    chk("fixed_resp0_out", b_resp0_out, 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
